// File: rtl/spi_pkg.sv
// spi_pkg: types and constants shared by the SPI slave core and the SPI bus BFMs.
package spi_pkg;
  localparam int sync_depth = 2;
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_state_t;
  typedef struct packed {
    logic polarity;
    logic phase;
  } spi_mode_t;
  // Returns {sample, shift} strobes from the synchronized sclk edges for a given mode.
  function automatic logic [1:0] spi_edges(input spi_mode_t mode, input logic rise, input logic fall);
    logic lead, trail;
    lead = mode.polarity ? fall : rise;
    trail = mode.polarity ? rise : fall;
    return mode.phase ? {trail, lead} : {lead, trail};
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: two-flop synchronizer for one SPI pin plus a third flop for rise/fall detection.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic init = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [sync_depth:0] sh_q, sh_d;
  always_comb sh_d = {sh_q[sync_depth-1:0], d};
  always_ff @(posedge clk) sh_q <= rst ? {(sync_depth + 1){init}} : sh_d;
  assign q = sh_q[sync_depth-1];
  assign rise = sh_q[sync_depth-1] & ~sh_q[sync_depth];
  assign fall = ~sh_q[sync_depth-1] & sh_q[sync_depth];
endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled SPI responder with a one-entry transmit holding register.
// Defining SPI_SLAVE_RX_OVERRUN_EN adds the rx_ack input and the sticky rx_overrun output.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter logic clk_polarity = 1'b0,
  parameter logic clk_phase    = 1'b0,
  parameter int   data_width   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic                  ss,
  input  logic [data_width-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [data_width-1:0] rx_data,
  output logic                  rx_valid
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  ,
  input  logic                  rx_ack,
  output logic                  rx_overrun
`endif
);
  localparam int cw = $clog2(data_width);
  localparam spi_mode_t mode = '{polarity: clk_polarity, phase: clk_phase};
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic ss_s, ss_rise, ss_fall;
  logic sample, shift, in_shift, load, reload, take, advance;
  logic unused_sync;
  logic [data_width-1:0] load_word;
  spi_state_t state_q, state_d;
  logic [data_width-1:0] tx_sr_q, tx_sr_d;
  logic [data_width-1:0] rx_sr_q, rx_sr_d;
  logic [data_width-1:0] hold_q, hold_d;
  logic [data_width-1:0] rx_data_q, rx_data_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic full_q, full_d;
  logic skip_q, skip_d;
  logic miso_q, miso_d;
  logic oe_q, oe_d;
  logic rx_valid_q, rx_valid_d;

  spi_sync_edge #(.init(clk_polarity)) u_sclk (
    .clk (clk),
    .rst (rst),
    .d   (sclk),
    .q   (sclk_s),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );
  spi_sync_edge #(.init(1'b0)) u_mosi (
    .clk (clk),
    .rst (rst),
    .d   (mosi),
    .q   (mosi_s),
    .rise(mosi_rise),
    .fall(mosi_fall)
  );
  spi_sync_edge #(.init(1'b1)) u_ss (
    .clk (clk),
    .rst (rst),
    .d   (ss),
    .q   (ss_s),
    .rise(ss_rise),
    .fall(ss_fall)
  );

  assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall, ss_s};
  assign {sample, shift} = spi_edges(mode, sclk_rise, sclk_fall);
  assign in_shift = (state_q == SHIFT) & ~ss_rise;
  assign take = tx_valid & ~full_q;
  assign reload = in_shift & sample & (cnt_q == cw'(data_width - 1));
  assign load = reload | ((state_q == IDLE) & ss_fall);
  assign advance = in_shift & shift & ~skip_q;
  // An empty holding register takes a same-cycle handshake straight through, else sends zeros.
  assign load_word = full_q ? hold_q : tx_valid ? tx_data : '0;

  always_comb begin
    state_d = ss_rise ? IDLE : state_q != IDLE ? SHIFT : ss_fall ? LOAD : IDLE;
    oe_d = ss_rise ? 1'b0 : load ? 1'b1 : oe_q;
    hold_d = take ? tx_data : hold_q;
    full_d = load ? 1'b0 : full_q | take;
    rx_sr_d = (in_shift & sample) ? {rx_sr_q[data_width-2:0], mosi_s} : rx_sr_q;
    cnt_d = load ? '0 : (in_shift & sample) ? cnt_q + 1'b1 : cnt_q;
    rx_data_d = reload ? rx_sr_d : rx_data_q;
    rx_valid_d = reload;
    // The shift edge right after a load would overwrite the MSB already on miso.
    skip_d = load ? (clk_phase | reload) : (in_shift & shift) ? 1'b0 : skip_q;
    tx_sr_d = load ? load_word : advance ? tx_sr_q << 1 : tx_sr_q;
    miso_d = ss_rise ? 1'b0 : load ? load_word[data_width-1] : advance ? tx_sr_q[data_width-2] : miso_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      hold_q <= '0;
      rx_data_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      skip_q <= 1'b0;
      miso_q <= 1'b0;
      oe_q <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      hold_q <= hold_d;
      rx_data_q <= rx_data_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      skip_q <= skip_d;
      miso_q <= miso_d;
      oe_q <= oe_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign miso = miso_q;
  assign miso_oe = oe_q;
  assign tx_ready = ~full_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_RX_OVERRUN_EN
  logic pend_q, pend_d, ovr_q, ovr_d;
  always_comb begin
    pend_d = reload | (pend_q & ~rx_ack);
    ovr_d = ~rx_ack & (ovr_q | (reload & pend_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovr_q <= ovr_d;
    end
  end
  assign rx_overrun = ovr_q;
`endif
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: directed bench driving one slave instance per SPI mode from a simple master model.
module tb_spi_slave_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mosi = 1'b0;
  logic [3:0] sclk = 4'b1100;
  logic [3:0] ss = 4'hF;
  logic [3:0] tx_valid = 4'h0;
  logic [3:0] miso, miso_oe, tx_ready, rx_valid;
  logic [3:0][15:0] tx_data = '0;
  logic [3:0][15:0] rx_data;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  logic [3:0] rx_ack = 4'h0;
  logic [3:0] rx_overrun;
`endif
  int checks = 0;
  int failures = 0;
  int nv[4];
  logic [15:0] got[4][8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_core #(
      .clk_polarity(1'(g >> 1)),
      .clk_phase   (1'(g & 1)),
      .data_width  (16)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .sclk    (sclk[g]),
      .mosi    (mosi),
      .miso    (miso[g]),
      .miso_oe (miso_oe[g]),
      .ss      (ss[g]),
      .tx_data (tx_data[g]),
      .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]),
      .rx_data (rx_data[g]),
      .rx_valid(rx_valid[g])
`ifdef SPI_SLAVE_RX_OVERRUN_EN
      ,
      .rx_ack    (rx_ack[g]),
      .rx_overrun(rx_overrun[g])
`endif
    );
  end

  always @(negedge clk)
    for (int m = 0; m < 4; m++)
      if (rx_valid[m] === 1'b1) begin
        if (nv[m] < 8) got[m][nv[m]] = rx_data[m];
        nv[m]++;
      end

  task automatic put_tx(input int m, input logic [15:0] d);
    bit done = 1'b0;
    @(negedge clk);
    tx_data[m] = d;
    tx_valid[m] = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      done = tx_ready[m];
      @(negedge clk);
    end
    tx_valid[m] = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL put_tx_handshake mode=%0d got=timeout want=tx_ready", m);
    end
  endtask

  task automatic ss_lo(input int m);
    @(negedge clk);
    ss[m] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (miso_oe[m] !== 1'b0) begin
      failures++;
      $display("FAIL oe_early mode=%0d got=%b want=0", m, miso_oe[m]);
    end
    @(negedge clk);
    checks++;
    if (miso_oe[m] !== 1'b1) begin
      failures++;
      $display("FAIL oe_rise mode=%0d got=%b want=1", m, miso_oe[m]);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic ss_hi(input int m);
    repeat (2) @(negedge clk);
    ss[m] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (miso_oe[m] !== 1'b1) begin
      failures++;
      $display("FAIL oe_hold mode=%0d got=%b want=1", m, miso_oe[m]);
    end
    @(negedge clk);
    checks++;
    if ({miso_oe[m], miso[m]} !== 2'b00) begin
      failures++;
      $display("FAIL oe_fall mode=%0d got=%b want=00", m, {miso_oe[m], miso[m]});
    end
  endtask

  // Master side: n bits MSB first, four clk cycles per sclk half period.
  task automatic xfer(input int m, input int n, input logic [15:0] d, output logic [15:0] q);
    logic pol, pha;
    pol = m[1];
    pha = m[0];
    q = '0;
    for (int i = 15; i > 15 - n; i--) begin
      if (pha) sclk[m] = ~pol;
      mosi = d[i];
      #40;
      sclk[m] = pha ? pol : ~pol;
      q[i] = miso[m];
      #40;
      if (!pha) sclk[m] = pol;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if ({miso[m], miso_oe[m], tx_ready[m], rx_valid[m]} !== 4'b0010) begin
        failures++;
        $display("FAIL reset_ctrl mode=%0d got=%b want=0010", m, {miso[m], miso_oe[m], tx_ready[m], rx_valid[m]});
      end
      checks++;
      if (rx_data[m] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_rx_data mode=%0d got=%h want=0000", m, rx_data[m]);
      end
`ifdef SPI_SLAVE_RX_OVERRUN_EN
      checks++;
      if (rx_overrun[m] !== 1'b0) begin
        failures++;
        $display("FAIL reset_overrun mode=%0d got=%b want=0", m, rx_overrun[m]);
      end
`endif
    end
  endtask

  task automatic test_mode0;
    logic [15:0] q;
    put_tx(0, 16'h0035);
    checks++;
    if (tx_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL m0_tx_ready_full got=%b want=0", tx_ready[0]);
    end
    ss_lo(0);
    checks++;
    if (tx_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL m0_tx_ready_loaded got=%b want=1", tx_ready[0]);
    end
    xfer(0, 16, 16'h0074, q);
    checks++;
    if (q !== 16'h0035) begin
      failures++;
      $display("FAIL m0_miso_word got=%h want=0035", q);
    end
    ss_hi(0);
    checks++;
    if (nv[0] !== 1) begin
      failures++;
      $display("FAIL m0_rx_valid_count got=%0d want=1", nv[0]);
    end
    checks++;
    if (got[0][0] !== 16'h0074 || rx_data[0] !== 16'h0074) begin
      failures++;
      $display("FAIL m0_rx_data got=%h/%h want=0074", got[0][0], rx_data[0]);
    end
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    checks++;
    if (rx_overrun[0] !== 1'b0) begin
      failures++;
      $display("FAIL m0_overrun got=%b want=0", rx_overrun[0]);
    end
`endif
  endtask

  task automatic test_modes;
    logic [15:0] q;
    for (int m = 1; m < 4; m++) begin
      put_tx(m, 16'hA5C3);
      ss_lo(m);
      xfer(m, 16, 16'hA5C3, q);
      ss_hi(m);
      checks++;
      if (q !== 16'hA5C3) begin
        failures++;
        $display("FAIL mode_miso mode=%0d got=%h want=a5c3", m, q);
      end
      checks++;
      if (nv[m] !== 1 || got[m][0] !== 16'hA5C3) begin
        failures++;
        $display("FAIL mode_rx mode=%0d got=%0d/%h want=1/a5c3", m, nv[m], got[m][0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] q1, q2;
    put_tx(0, 16'h1111);
    ss_lo(0);
    checks++;
    if (tx_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_first got=%b want=1", tx_ready[0]);
    end
    put_tx(0, 16'h2222);
    checks++;
    if (tx_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready_held got=%b want=0", tx_ready[0]);
    end
    xfer(0, 16, 16'hBEEF, q1);
    checks++;
    if (tx_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_reload got=%b want=1", tx_ready[0]);
    end
    xfer(0, 16, 16'hCAFE, q2);
    ss_hi(0);
    checks++;
    if (q1 !== 16'h1111 || q2 !== 16'h2222) begin
      failures++;
      $display("FAIL b2b_miso got=%h,%h want=1111,2222", q1, q2);
    end
    checks++;
    if (nv[0] !== 3 || got[0][1] !== 16'hBEEF || got[0][2] !== 16'hCAFE) begin
      failures++;
      $display("FAIL b2b_rx got=%0d:%h,%h want=3:beef,cafe", nv[0], got[0][1], got[0][2]);
    end
  endtask

  task automatic test_overrun;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    checks++;
    if (rx_overrun[0] !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got=%b want=1", rx_overrun[0]);
    end
    @(negedge clk);
    rx_ack[0] = 1'b1;
    @(negedge clk);
    rx_ack[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_overrun[0] !== 1'b0) begin
      failures++;
      $display("FAIL overrun_ack got=%b want=0", rx_overrun[0]);
    end
`endif
  endtask

  task automatic test_partial;
    logic [15:0] q;
    ss_lo(0);
    xfer(0, 7, 16'hFFFF, q);
    ss_hi(0);
    checks++;
    if (nv[0] !== 3 || rx_data[0] !== 16'hCAFE) begin
      failures++;
      $display("FAIL partial_discard got=%0d:%h want=3:cafe", nv[0], rx_data[0]);
    end
    ss_lo(0);
    xfer(0, 16, 16'h0F0F, q);
    ss_hi(0);
    checks++;
    if (nv[0] !== 4 || got[0][3] !== 16'h0F0F) begin
      failures++;
      $display("FAIL partial_recover got=%0d:%h want=4:0f0f", nv[0], got[0][3]);
    end
    checks++;
    if (q !== 16'h0000) begin
      failures++;
      $display("FAIL partial_empty_tx got=%h want=0000", q);
    end
  endtask

  task automatic test_no_tx;
    logic [15:0] q;
    ss_lo(3);
    xfer(3, 16, 16'h1234, q);
    ss_hi(3);
    checks++;
    if (q !== 16'h0000) begin
      failures++;
      $display("FAIL no_tx_miso got=%h want=0000", q);
    end
    checks++;
    if (nv[3] !== 2 || got[3][1] !== 16'h1234) begin
      failures++;
      $display("FAIL no_tx_rx got=%0d:%h want=2:1234", nv[3], got[3][1]);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] q;
    put_tx(1, 16'h7777);
    ss_lo(1);
    put_tx(1, 16'h9999);
    xfer(1, 5, 16'hFFFF, q);
    @(negedge clk);
    rst = 1'b1;
    ss[1] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({miso_oe[1], miso[1], tx_ready[1]} !== 3'b001) begin
      failures++;
      $display("FAIL rst_mid_ctrl got=%b want=001", {miso_oe[1], miso[1], tx_ready[1]});
    end
    checks++;
    if (rx_data[1] !== 16'h0000) begin
      failures++;
      $display("FAIL rst_mid_rx_data got=%h want=0000", rx_data[1]);
    end
    rst = 1'b0;
    ss_lo(1);
    xfer(1, 16, 16'h5A5A, q);
    ss_hi(1);
    checks++;
    if (q !== 16'h0000) begin
      failures++;
      $display("FAIL rst_mid_hold_flushed got=%h want=0000", q);
    end
    checks++;
    if (nv[1] !== 2 || got[1][1] !== 16'h5A5A) begin
      failures++;
      $display("FAIL rst_mid_rx got=%0d:%h want=2:5a5a", nv[1], got[1][1]);
    end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_modes;
    test_back_to_back;
    test_overrun;
    test_partial;
    test_no_tx;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

Synthesizable SPI responder that lets the FPGA fabric sit on the far end of the bus driven by `spi_master_bfm`. It oversamples `sclk`, `mosi` and `ss` on the system clock and shifts a parallel word in and out per SPI transaction. It hands received words to the fabric on a valid strobe and takes transmit words through a valid/ready handshake. Its pin-level behaviour matches `spi_slave_bfm`, so the two are interchangeable in benches.

## Interface
- `clk_polarity`, 0: idle level of `sclk`.
- `clk_phase`, 0: 0 means sample on the leading edge and shift on the trailing edge; 1 means the reverse.
- `data_width`, 16: bits per word, MSB first, minimum 2.

Ports:
- `clk` in 1: system clock; must be at least 8× `sclk`.
- `rst` in 1: synchronous, active-high reset.
- `sclk` in 1: SPI clock, asynchronous to `clk`.
- `mosi` in 1: serial data from the master.
- `miso` out 1: serial data to the master.
- `miso_oe` out 1: tristate enable for `miso`; high only while selected.
- `ss` in 1: slave select, active low.
- `tx_data` in `data_width`: next word to transmit.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: transmit holding register is empty.
- `rx_data` out `data_width`: last complete received word.
- `rx_valid` out 1: one-cycle strobe; `rx_data` is new.

## Operation
- Each of `sclk`, `mosi` and `ss` passes through a 2-flop synchronizer. Edge detection compares the second flop with a third.
- Leading edge is rising when `clk_polarity`=0 and falling when it is 1. The sample edge is the leading edge when `clk_phase`=0, otherwise the trailing edge. The shift edge is the other one.
- Transmit holding register: one entry. A transfer occurs when `tx_valid && tx_ready`. `tx_ready` drops the cycle after the transfer and rises again when the word moves into the shift register.
- State machine:
  - IDLE: `miso_oe`=0 and `miso`=0.
  - IDLE → LOAD on synchronized `ss` falling.
  - LOAD (one cycle): copy the holding register into the tx shift register, or all-zeros if it is empty; clear the bit counter; drive the MSB onto `miso`; go to SHIFT.
  - SHIFT: on each sample edge, shift `mosi` into the rx shift register and increment the bit counter.
  - SHIFT, shift edge: advance `miso` to the next bit. When `clk_phase`=1, skip the first shift edge of each word because the MSB is already on `miso`.
  - SHIFT, on the `data_width`th sample edge: copy the rx shift register to `rx_data`, pulse `rx_valid`, clear the counter, and reload from the holding register for back-to-back words while `ss` stays low.
  - Any state → IDLE on synchronized `ss` rising. A partial word is discarded: no `rx_valid`, and `rx_data` is unchanged. If a word was loaded from the holding register, it is consumed and not retransmitted.
- Holding register empty at load time: all-zeros word is sent. This is not an error.
- A held `rst` overrides everything. Asserting reset mid-transaction returns to IDLE and empties the holding register.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0. State is IDLE and the counter is 0.
- `miso_oe` rises 3 `clk` cycles after `ss` falls at the pin (2 synchronizer cycles plus LOAD). It falls 3 cycles after `ss` rises.
- `miso` updates 3 `clk` cycles after the shift edge at the pin. This limits `sclk` to at most `clk`/8 so that half-period setup is met at the master.
- `rx_valid` rises 3 `clk` cycles after the final sample edge at the pin and lasts exactly 1 cycle.
- A `tx_valid` handshake completing in the same cycle as a reload is used for the reload: the new word bypasses the holding register and `tx_ready` stays high.

## Configuration
- `SPI_SLAVE_RX_OVERRUN_EN` defined: adds the output port `rx_overrun` (1 bit, reset value 0).
  - It is a sticky flag, set when a word completes while `rx_ack` has not been asserted since the previous `rx_valid`.
  - It adds the input port `rx_ack` (1 bit). `rx_ack` and `rst` clear the flag.
- Not defined: neither port exists, and every word overwrites `rx_data` silently.

## Structure
- Package `spi_pkg` holds the state enum (`IDLE`, `LOAD`, `SHIFT`), the `spi_mode_t` struct (polarity, phase), and the synchronizer depth constant, fixed at 2. The BFMs share this package.
- Sub-module `spi_sync_edge`: synchronizer plus rise/fall detector, instantiated 3 times.

## Test plan
- Mode 0, 16-bit, `tx_data`=16'h0035 preloaded; master BFM writes 16'h0074 → `rx_data`=16'h0074 with a single `rx_valid`; master reads 16'h0035.
- Modes 1, 2 and 3, each with 16'hA5C3 in both directions → exact round trip and no bit slip.
- Two back-to-back words under one `ss` low, tx 16'h1111 then 16'h2222, rx 16'hBEEF then 16'hCAFE → 2 `rx_valid` pulses in order; `tx_ready` toggles between them.
- `ss` deasserted after 7 bits → no `rx_valid`, `rx_data` unchanged, and the next full transaction of 16'h0F0F is received correctly.
- No `tx_valid` before `ss` falls → master reads 16'h0000.
- With `SPI_SLAVE_RX_OVERRUN_EN` defined: two words with no `rx_ack` → `rx_overrun`=1; after `rx_ack` → 0.
